// File: rtl/custom_types_pkg.sv
// Shared fetch-stage types: FSM states, fetch/decode latch bundle,
// PC increment and a saturating-increment helper.
package custom_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        valid;
  } fetch_latch_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_stats.sv
// Saturating predictor statistics counters,
// built only when BP_STATS_EN is defined.
module fetch_stats
  import custom_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        branch_inc,
  input  logic        mispredict_inc,
  output logic [31:0] branches,
  output logic [31:0] mispredicts
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      branches    <= '0;
      mispredicts <= '0;
    end else begin
      if (branch_inc)
        branches <= sat_inc(branches);
      if (mispredict_inc)
        mispredicts <= sat_inc(mispredicts);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC, next-PC select, redirect hold and fetch/decode latch.
// Optional statistics counters under `BP_STATS_EN.
module pc_fetch_unit
  import custom_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic [31:0] imemaddr,
  output logic        iREN,
  input  logic        stall,
  input  logic        halt,
  input  logic        bp_taken,
  input  logic [31:0] bp_target,
  input  logic        branch_mispredict,
  input  logic [31:0] correct_pc,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  output logic        flush_fd,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_npc,
  output logic        fetch_pred_taken,
  output logic [31:0] fetch_pred_target,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  fetch_state_t state;
  fetch_latch_t lat;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] redir_tgt;
  logic [31:0] pend;
  logic [31:0] pend_nxt;
  logic        pend_jump;
  logic        pend_jump_nxt;
  logic        live;
  logic        redir;

  assign live      = (state != HALTED);
  assign redir     = live &&
                     (branch_mispredict || jump_valid);
  assign redir_tgt = branch_mispredict ? correct_pc
                                       : jump_target;
  assign pc_plus4  = pc + PC_STEP;

  // A mispredict is older than any jump, so a jump
  // may only replace a pending target set by a jump.
  always_comb begin
    pend_nxt      = pend;
    pend_jump_nxt = pend_jump;
    unique case (1'b1)
      branch_mispredict: begin
        pend_nxt      = correct_pc;
        pend_jump_nxt = 1'b0;
      end
      jump_valid && pend_jump && !branch_mispredict: begin
        pend_nxt      = jump_target;
        pend_jump_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      pc        <= PC_INIT;
      pend      <= '0;
      pend_jump <= 1'b0;
      lat       <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (redir) begin
            lat.valid <= 1'b0;
            if (ihit) begin
              pc <= redir_tgt;
            end else begin
              pend      <= redir_tgt;
              pend_jump <= !branch_mispredict;
              state     <= HOLD;
            end
          end else if (halt) begin
            lat.valid <= 1'b0;
            state     <= HALTED;
          end else if (!stall) begin
            if (ihit) begin
              lat <= '{instr:       imemload,
                       pc:          pc,
                       npc:         pc_plus4,
                       pred_taken:  bp_taken,
                       pred_target: bp_target,
                       valid:       1'b1};
              pc  <= bp_taken ? bp_target
                              : pc_plus4;
            end else begin
              lat.valid <= 1'b0;
            end
          end
        end
        HOLD: begin
          lat.valid <= 1'b0;
          if (halt && !redir) begin
            state <= HALTED;
          end else begin
            pend      <= pend_nxt;
            pend_jump <= pend_jump_nxt;
            if (ihit) begin
              pc    <= pend_nxt;
              state <= RUN;
            end
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

  assign imemaddr          = pc;
  assign iREN              = live && !RST;
  assign flush_fd          = redir;
  assign fetch_valid       = lat.valid;
  assign fetch_instr       = lat.instr;
  assign fetch_pc          = lat.pc;
  assign fetch_npc         = lat.npc;
  assign fetch_pred_taken  = lat.pred_taken;
  assign fetch_pred_target = lat.pred_target;

`ifdef BP_STATS_EN
  logic br_inc;
  logic mp_inc;

  assign br_inc = (state == RUN) && !redir &&
                  !halt && !stall && ihit &&
                  bp_taken;
  assign mp_inc = live && branch_mispredict;

  fetch_stats u_stats (
    .CLK            (CLK),
    .RST            (RST),
    .branch_inc     (br_inc),
    .mispredict_inc (mp_inc),
    .branches       (stat_branches),
    .mispredicts    (stat_mispredicts)
  );
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
